// File: rtl/bf_uart_tx_pkg.sv
// Shared definitions for the BF CPU UART transmit path: serializer states and
// default line timing for the iCEBreaker board.
package bf_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLK_HZ = 12_000_000;
    localparam int DEF_BAUD   = 115_200;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/bf_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; occupancy is kept
// as an explicit count so full/empty never need pointer comparison.
module bf_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only readable once written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bf_uart_tx.sv
// UART 8N1 transmitter for the BF CPU '.' output stream: byte FIFO on the CPU
// side (valid/ready) feeding a registered-output serializer.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line high, waiting for a buffered byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first, one bit period each
//   STOP  | stop bit (high); last cycle chains straight into the next frame
module bf_uart_tx
    import bf_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_last;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;

    // Ready depends only on the registered count, so a full FIFO refuses a
    // push even on the cycle it pops.
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign baud_last = (baud_q == BAUD_LAST);
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign tx        = tx_q;

    bf_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Self-checking bench for bf_uart_tx: a mid-bit line sampler decodes frames and
// a byte queue scoreboard holds everything the CPU side handed over.
module tb_bf_uart_tx;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 115_200;
    localparam int DEPTH  = 4;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * CPB;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    byte unsigned exp_q[$];
    int           st_q[$];

    bf_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Line decoder: start found on the first low sample, bits sampled mid-period.
    logic       mon_busy = 1'b0;
    int         mon_start = 0;
    int         mon_k;
    int         mon_i;
    logic [9:0] mon_bits;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy  = 1'b1;
                mon_start = cyc;
                st_q.push_back(cyc);
            end
        end else begin
            mon_k = cyc - mon_start;
            if (mon_k >= CPB / 2 && (mon_k - CPB / 2) % CPB == 0) begin
                mon_i = (mon_k - CPB / 2) / CPB;
                mon_bits[mon_i] = tx;
                if (mon_i == 9) begin
                    mon_busy = 1'b0;
                    check("start_bit", 32'(mon_bits[0]), 0);
                    check("stop_bit", 32'(mon_bits[9]), 1);
                    if (exp_q.size() == 0)
                        check("rx_unexpected", 32'(mon_bits[8:1]), 256);
                    else
                        check("rx_byte", 32'(mon_bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", 32'(n < 5000), 1);
        acc = cyc + 1;
        exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 20000), 1);
        check({tag, "_idle_tx"}, 32'(tx), 1);
        check({tag, "_idle_count"}, 32'(fifo_count), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        int low;
        int n;
        int acc[6];
        logic [7:0] hello[5];
        int hello_cnt[5];

        hello     = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        hello_cnt = '{1, 1, 2, 3, 4};

        // reset values and quiet line afterwards
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        resetn = 1'b1;
        low = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
        end
        check("idle_tx_low_cycles", 32'(low), 0);
        check("idle_busy", 32'(busy), 0);

        // single byte: latency, frame length, busy release
        st_q.delete();
        push_byte(8'h41, a);
        check("lat_tx_before", 32'(tx), 1);
        @(negedge clk);
        check("lat_tx_fall", 32'(tx), 0);
        while (cyc < a + FRAME) @(negedge clk);
        check("busy_last_stop", 32'(busy), 1);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 0);
        check("single_start_cycle", 32'(st_q.size() > 0 ? st_q[0] : -1), 32'(a + 1));
        drain("single");

        // "Hello" burst: accepted back-to-back, frames contiguous
        st_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_byte(hello[i], acc[i]);
            check("burst_count", 32'(fifo_count), 32'(hello_cnt[i]));
            check("burst_accept_cycle", 32'(acc[i] - acc[0]), 32'(i));
        end
        drain("burst");
        check("burst_frames", 32'(st_q.size()), 5);
        for (int i = 1; i < 5 && i < st_q.size(); i++)
            check("burst_frame_gap", 32'(st_q[i] - st_q[i-1]), 32'(FRAME));

        // full FIFO: sixth byte waits for the second pop
        for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)), acc[i]);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        push_byte(8'($urandom_range(0, 255)), acc[5]);
        check("full_sixth_accept", 32'(acc[5] - acc[0]), 32'(FRAME + 2));
        drain("full");

        // push coinciding with the stop-end pop keeps the count
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), acc[i]);
        check("pp_count_before", 32'(fifo_count), 2);
        n = 0;
        while (cyc < acc[0] + FRAME && n < 5000) begin
            @(negedge clk);
            n++;
        end
        push_byte(8'($urandom_range(0, 255)), acc[3]);
        check("pp_accept_cycle", 32'(acc[3] - acc[0]), 32'(FRAME + 1));
        check("pp_count_after", 32'(fifo_count), 2);
        drain("pushpop");

        // reset mid-DATA with three bytes queued
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)), acc[i]);
        check("mid_count", 32'(fifo_count), 3);
        repeat (300) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx), 1);
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        st_q.delete();
        push_byte(8'h55, a);
        @(negedge clk);
        check("post_rst_tx_fall", 32'(tx), 0);
        drain("post_rst");
        check("post_rst_frames", 32'(st_q.size()), 1);
        check("post_rst_start", 32'(st_q.size() > 0 ? st_q[0] : -1), 32'(a + 1));

        // random bursts with random gaps against the scoreboard
        repeat (4) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                push_byte(8'($urandom_range(0, 255)), a);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
